// File: rtl/grf_dumper.sv
// Debug reader for the CPU register file: freezes the core, walks GRF read port 1
// and streams every (address, value) pair over a valid/ready handshake.
module grf_dumper #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    output logic              stall,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'((SKIP_ZERO != 0) ? 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              stall_q, stall_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stall_d     = stall_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = FIRST_IDX;
                    stall_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // Snapshot the read port so later GRF activity cannot alter the beat.
                out_data_d  = rd_data;
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        stall_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            stall_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stall_q     <= stall_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign stall     = stall_q;
    assign rd_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule
